// File: rtl/apb_multi_slave_bridge.sv
// APB4 requester with an N-way slave decoder/mux: one request in flight, byte strobes,
// decode-error and PREADY-timeout detection, single registered response per request.
module apb_multi_slave_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned SEL_LSB        = 12,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/8-1:0]          req_strb,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [1:0]                       rsp_err,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_BITS   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 0;
    localparam int unsigned IDX_W      = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int unsigned HI_LSB     = SEL_LSB + IDX_BITS;
    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_SLV  = 2'b01;
    localparam logic [1:0] ERR_DEC  = 2'b10;
    localparam logic [1:0] ERR_TOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_err_q, rsp_err_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [IDX_W-1:0]        dec_idx;
    logic                    dec_err;
    logic [NUM_SLAVES-1:0]   dec_onehot;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;

    // Slave index field; a single slave has no index bits at all.
    generate
        if (NUM_SLAVES > 1) begin : g_idx
            assign dec_idx = req_addr[SEL_LSB +: IDX_W];
        end else begin : g_idx_single
            assign dec_idx = '0;
        end
    endgenerate

    // Decode error: index out of range or any address bit above the index field set.
    always_comb begin
        dec_err = (32'(dec_idx) >= NUM_SLAVES);
        for (int i = 0; i < int'(ADDR_WIDTH); i++) begin
            if (i >= int'(HI_LSB)) begin
                dec_err = dec_err | req_addr[i];
            end
        end
    end

    always_comb begin
        dec_onehot = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            dec_onehot[i] = (dec_idx == IDX_W'(i));
        end
    end

    // Only the selected slave's response lines are observed.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (dec_err) begin
                        // Decode failures answer directly without touching the bus.
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = ERR_DEC;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d  = S_SETUP;
                        idx_d    = dec_idx;
                        psel_d   = dec_onehot;
                        pwrite_d = req_write;
                        paddr_d  = req_addr;
                        pwdata_d = req_wdata;
                        pstrb_d  = req_write ? req_strb : '0;
                    end
                end
            end

            S_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_ACCESS;
            end

            S_ACCESS: begin
                if (sel_ready) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err ? ERR_SLV : ERR_OK;
                    rsp_rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
                    state_d     = S_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_TOUT;
                    rsp_rdata_d = '0;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;

endmodule

// File: tb/tb_apb_multi_slave_bridge.sv
// Bench for apb_multi_slave_bridge: directed requests, expected responses queued and
// checked by an independent response monitor, plus in-line bus timing checks.
module tb_apb_multi_slave_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NS = 4;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 8;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic [SW-1:0]     req_strb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_rdata;
    logic [1:0]        rsp_err;
    logic [NS-1:0]     PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [SW-1:0]     PSTRB;
    logic [NS*DW-1:0]  PRDATA;
    logic [NS-1:0]     PREADY;
    logic [NS-1:0]     PSLVERR;

    apb_multi_slave_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
        .SEL_LSB(12), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Slave models: fixed per-slave read data, programmable wait states / stuck / error.
    int            wait_cfg [NS];
    logic [NS-1:0] stuck;
    logic [NS-1:0] slverr;
    int            acc_cnt = 0;

    assign PRDATA  = {32'h12345678, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A00000};
    assign PSLVERR = slverr;

    always @(posedge PCLK) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

    always_comb begin
        for (int i = 0; i < int'(NS); i++) begin
            PREADY[i] = !stuck[i] && (acc_cnt >= wait_cfg[i]);
        end
    end

    // Scoreboard: expected responses queued by stimulus, popped on each response handshake.
    typedef struct packed {
        logic [DW-1:0] rdata;
        logic [1:0]    err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t exp_e;
    int   n_rsp      = 0;
    int   psel_cyc   = 0;
    int   proto_bad  = 0;

    always @(negedge PCLK) begin
        if (rsp_valid && rsp_ready) begin
            n_rsp = n_rsp + 1;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rsp: got a response, expected none (rdata 0x%0h err %0d)",
                         rsp_rdata, rsp_err);
            end else begin
                exp_e = exp_q.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(exp_e.err));
            end
        end
        if (PSEL != '0) psel_cyc = psel_cyc + 1;
        if (($countones(PSEL) > 1) || (PENABLE && (PSEL == '0))) proto_bad = proto_bad + 1;
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [SW-1:0] s, input logic [DW-1:0] erd, input logic [1:0] eerr);
        int   guard;
        rsp_t e;
        guard   = 0;
        e.rdata = erd;
        e.err   = eerr;
        exp_q.push_back(e);
        @(negedge PCLK);
        while (!req_ready && guard < 50) begin
            @(negedge PCLK);
            guard++;
        end
        chk("req_ready_before_accept", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        req_strb  = s;
        @(posedge PCLK);
        @(negedge PCLK);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int guard;
        guard = 0;
        while ((!req_ready || rsp_valid) && guard < 100) begin
            @(negedge PCLK);
            guard++;
        end
        chk({name, "_back_to_idle"}, 64'(req_ready && !rsp_valid), 64'(1));
        chk({name, "_all_rsp_seen"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_req_ready"}, 64'(req_ready), 64'(1));
        chk({name, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({name, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        chk({name, "_rsp_err"},   64'(rsp_err),   64'(0));
        chk({name, "_psel"},      64'(PSEL),      64'(0));
        chk({name, "_penable"},   64'(PENABLE),   64'(0));
        chk({name, "_pwrite"},    64'(PWRITE),    64'(0));
        chk({name, "_paddr"},     64'(PADDR),     64'(0));
        chk({name, "_pwdata"},    64'(PWDATA),    64'(0));
        chk({name, "_pstrb"},     64'(PSTRB),     64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int n_acc;
        int guard;
        int snap;
        int stable;
        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        rsp_ready = 1'b1;
        stuck     = '0;
        slverr    = '0;
        for (int i = 0; i < int'(NS); i++) wait_cfg[i] = 0;
        #12;
        chk_reset("por");
        @(negedge PCLK);
        PRESET = 1'b0;

        // Zero-wait write to slave 1.
        send(1'b1, 32'h0000_1004, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00);
        chk("t1_setup_psel", 64'(PSEL), 64'(4'b0010));
        chk("t1_setup_penable", 64'(PENABLE), 64'(0));
        chk("t1_paddr", 64'(PADDR), 64'(32'h0000_1004));
        chk("t1_pwdata", 64'(PWDATA), 64'(32'hDEADBEEF));
        chk("t1_pstrb", 64'(PSTRB), 64'(4'hF));
        chk("t1_pwrite", 64'(PWRITE), 64'(1));
        @(negedge PCLK);
        chk("t1_access_psel", 64'(PSEL), 64'(4'b0010));
        chk("t1_access_penable", 64'(PENABLE), 64'(1));
        chk("t1_access_paddr", 64'(PADDR), 64'(32'h0000_1004));
        @(negedge PCLK);
        chk("t1_rsp_valid_t3", 64'(rsp_valid), 64'(1));
        chk("t1_bus_released", 64'({PSEL, PENABLE}), 64'(0));
        chk("t1_no_accept_in_resp", 64'(req_ready), 64'(0));
        wait_done("t1");

        // Partial-strobe write to slave 1.
        send(1'b1, 32'h0000_1008, 32'h0055_00AA, 4'b0101, 32'h0, 2'b00);
        chk("t1b_pstrb", 64'(PSTRB), 64'(4'b0101));
        wait_done("t1b");

        // Read slave 3 with 5 wait states; other slaves ready with different data.
        wait_cfg[3] = 5;
        send(1'b0, 32'h0000_3010, 32'hFFFF_FFFF, 4'hF, 32'h12345678, 2'b00);
        chk("t2_psel", 64'(PSEL), 64'(4'b1000));
        chk("t2_pstrb_read", 64'(PSTRB), 64'(0));
        chk("t2_pwrite", 64'(PWRITE), 64'(0));
        @(negedge PCLK);
        n_acc = 0;
        guard = 0;
        while (PENABLE && guard < 100) begin
            n_acc++;
            @(negedge PCLK);
            guard++;
        end
        chk("t2_access_cycles", 64'(n_acc), 64'(6));
        chk("t2_rsp_valid", 64'(rsp_valid), 64'(1));
        wait_done("t2");
        wait_cfg[3] = 0;

        // Decode errors: out-of-range index and high address bit.
        snap = psel_cyc;
        send(1'b0, 32'h0000_5000, 32'h0, 4'h0, 32'h0, 2'b10);
        chk("t3a_rsp_t1", 64'(rsp_valid), 64'(1));
        chk("t3a_psel", 64'(PSEL), 64'(0));
        wait_done("t3a");
        send(1'b0, 32'h1000_0000, 32'h0, 4'h0, 32'h0, 2'b10);
        chk("t3b_rsp_t1", 64'(rsp_valid), 64'(1));
        wait_done("t3b");
        chk("t3_psel_never", 64'(psel_cyc - snap), 64'(0));

        // Slave error on read from slave 2 forces rdata to zero.
        slverr[2] = 1'b1;
        send(1'b0, 32'h0000_2000, 32'h0, 4'h0, 32'h0, 2'b01);
        wait_done("t4");
        slverr[2] = 1'b0;

        // Timeout on slave 0, then a normal read from the same slave.
        stuck[0] = 1'b1;
        send(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0, 2'b11);
        @(negedge PCLK);
        n_acc = 0;
        guard = 0;
        while (PENABLE && guard < 100) begin
            n_acc++;
            @(negedge PCLK);
            guard++;
        end
        chk("t5_access_cycles", 64'(n_acc), 64'(TO));
        chk("t5_psel_dropped", 64'(PSEL), 64'(0));
        chk("t5_rsp_valid", 64'(rsp_valid), 64'(1));
        wait_done("t5");
        stuck[0] = 1'b0;
        send(1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'hA0A00000, 2'b00);
        wait_done("t5b");

        // Response back-pressure for 10 cycles.
        rsp_ready = 1'b0;
        send(1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'hB1B1B1B1, 2'b00);
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(negedge PCLK);
            guard++;
        end
        stable = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid && !req_ready && (rsp_rdata == 32'hB1B1B1B1) && (rsp_err == 2'b00))
                stable++;
            @(negedge PCLK);
        end
        chk("t6_hold_cycles", 64'(stable), 64'(10));
        @(posedge PCLK);
        #1 rsp_ready = 1'b1;
        wait_done("t6");

        // Asynchronous reset during ACCESS drops the transfer.
        stuck[0] = 1'b1;
        send(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h0, 2'b11);
        @(negedge PCLK);
        @(negedge PCLK);
        chk("t7_in_access", 64'(PENABLE), 64'(1));
        snap = n_rsp;
        #2 PRESET = 1'b1;
        #1;
        chk_reset("t7_async");
        exp_q.delete();
        @(negedge PCLK);
        PRESET   = 1'b0;
        stuck[0] = 1'b0;
        for (int k = 0; k < 12; k++) @(negedge PCLK);
        chk("t7_no_rsp", 64'(n_rsp - snap), 64'(0));
        send(1'b0, 32'h0000_3000, 32'h0, 4'h0, 32'h12345678, 2'b00);
        wait_done("t7b");

        chk("protocol_onehot_enable", 64'(proto_bad), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
